// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: runs each access as a byte-serial req/ack
// sequence on a byte-wide data port and returns the extended load result.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] Mem_Addr,
  input  logic [63:0]       Write_Data,
  output logic [63:0]       Read_Data,
  output logic              stall,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [63:0]       r_wdata;
  logic [63:0]       r_buf;
  logic [63:0]       r_rdata;
  logic [2:0]        r_f3;
  logic              r_is_load;
  logic [2:0]        r_idx;
  logic [7:0]        r_wait;
  logic              r_fault;

  logic              w_req;
  logic              w_illegal;
  logic              w_hs;
  logic              w_last;
  logic              w_timeout;
  logic [63:0]       w_buf_merge;

  function automatic logic [2:0] last_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    last_idx = 3'd0;
      2'd1:    last_idx = 3'd1;
      2'd2:    last_idx = 3'd3;
      default: last_idx = 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] b, input logic [2:0] f3);
    logic s;
    s = ~f3[2];
    case (f3[1:0])
      2'd0:    extend = {{56{s & b[7]}},  b[7:0]};
      2'd1:    extend = {{48{s & b[15]}}, b[15:0]};
      2'd2:    extend = {{32{s & b[31]}}, b[31:0]};
      default: extend = b;
    endcase
  endfunction

  assign w_req     = MemRead | MemWrite;
  assign w_illegal = MemRead ? (funct3 == 3'b111) : funct3[2];
  assign w_hs      = (r_state == S_XFER) & mem_ack;
  assign w_last    = (r_idx == last_idx(r_f3));
  assign w_timeout = (r_state == S_XFER) & ~mem_ack & (r_wait == 8'(TIMEOUT - 1));

  always_comb begin
    w_buf_merge = r_buf;
    w_buf_merge[{r_idx, 3'b000} +: 8] = mem_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = w_illegal ? S_DONE : S_XFER;
      S_XFER: if ((w_hs & w_last) | w_timeout) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stall in IDLE is gated by reset so the pipeline is released the moment reset asserts.
  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: stall = w_req & reset_n;
      S_XFER: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = ~r_is_load;
        mem_addr  = r_base + ADDR_W'(r_idx);
        mem_wdata = r_wdata[{r_idx, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= '0;
      r_wait  <= '0;
      r_fault <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_fault <= ((r_state == S_IDLE) & w_req & w_illegal) | w_timeout;
      if (r_state == S_IDLE) begin
        r_idx  <= '0;
        r_wait <= '0;
        if (w_req & w_illegal & MemRead) r_rdata <= '0;
      end else if (r_state == S_XFER) begin
        if (w_hs) begin
          r_wait <= '0;
          if (w_last) begin
            if (r_is_load) r_rdata <= extend(w_buf_merge, r_f3);
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end else if (w_timeout) begin
          r_wait <= '0;
          if (r_is_load) r_rdata <= '0;
        end else begin
          r_wait <= r_wait + 8'd1;
        end
      end
    end
  end

  // Request capture and load assembly buffer carry no reset; they are only read in XFER.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) & w_req) begin
      r_base    <= Mem_Addr;
      r_wdata   <= Write_Data;
      r_f3      <= funct3;
      r_is_load <= MemRead;
    end
    if (w_hs) r_buf <= w_buf_merge;
  end

  assign Read_Data = r_rdata;
  assign fault     = r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte memory model with scripted ack delays,
// expected results computed from the access rules with plain arithmetic.
module tb_mem_access_unit;
  localparam int TIMEOUT = 16;
  localparam int ADDR_W  = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              MemRead, MemWrite;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [63:0]       Write_Data;
  logic [63:0]       Read_Data;
  logic              stall, fault, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;
  logic              mem_ack;

  logic [7:0] mem [256];
  int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;
  logic [63:0] exp_rd = '0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:0]];

  mem_access_unit #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
    .Read_Data(Read_Data), .stall(stall), .fault(fault), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: wb = byte index that gets wn extra wait cycles; stuck = ack never comes.
  task automatic run(input bit ld, input logic [2:0] f3, input logic [7:0] addr,
                     input logic [63:0] wd, input int wb, input int wn, input bit stuck);
    int size, k, waited, nstall, nreq, exp_req;
    bit illegal, done;
    logic [63:0] val;
    size    = 1 << f3[1:0];
    illegal = ld ? (f3 == 3'b111) : f3[2];
    val = '0;
    for (int i = 0; i < size; i++) val |= 64'(mem[8'(addr + i)]) << (8 * i);
    if (ld && !f3[2] && size < 8 && val[8*size-1]) val |= ~((64'd1 << (8 * size)) - 64'd1);
    exp_req = illegal ? 0 : stuck ? TIMEOUT : size + ((wb < size) ? wn : 0);

    @(negedge clk);
    MemRead = ld; MemWrite = !ld; funct3 = f3;
    Mem_Addr = ADDR_W'(addr); Write_Data = wd;
    k = 0; waited = 0; nstall = 0; nreq = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (c > 0) @(negedge clk);
      mem_ack = !stuck && !(k == wb && waited < wn);
      #1;
      if (mem_req) begin
        nreq++;
        check("req_addr", mem_addr, 64'(addr) + 64'(k));
        check("req_we", 64'(mem_we), 64'(!ld));
        if (!ld) check("req_wdata", 64'(mem_wdata), 64'(wd[8*k +: 8]));
        if (mem_ack) begin
          if (!ld) mem[8'(addr + k)] = mem_wdata;
          k++; waited = 0;
        end else waited++;
      end
      if (stall) nstall++;
      else begin
        done = 1;
        if (ld) exp_rd = (illegal || stuck) ? 64'd0 : val;
        check("done_fault", 64'(fault), 64'(illegal || stuck));
        check("done_rdata", Read_Data, exp_rd);
        check("done_mem_req", 64'(mem_req), 64'd0);
      end
    end
    check("completed", 64'(done), 64'd1);
    check("req_cycles", 64'(nreq), 64'(exp_req));
    check("stall_cycles", 64'(nstall), 64'(exp_req + 1));
    @(negedge clk);
    MemRead = 0; MemWrite = 0; mem_ack = 0;
    #1;
    check("idle_fault", 64'(fault), 64'd0);
    check("idle_stall", 64'(stall), 64'd0);
    check("idle_rdata", Read_Data, exp_rd);
  endtask

  initial begin
    reset_n = 0; MemRead = 0; MemWrite = 0; funct3 = 0;
    Mem_Addr = '0; Write_Data = '0; mem_ack = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #1;
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_rdata", Read_Data, 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    check("rst_we_wdata", {55'd0, mem_we, mem_wdata}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1;

    mem[0] = 8'h03;
    for (int i = 1; i < 8; i++) mem[i] = 8'h00;
    run(1, 3'b011, 8'h00, 64'd0, 8, 0, 0);
    check("t1_ld", Read_Data, 64'h3);
    mem[8] = 8'h80;
    run(1, 3'b000, 8'h08, 64'd0, 8, 0, 0);
    check("t2_lb", Read_Data, 64'hFFFFFFFFFFFFFF80);
    run(1, 3'b100, 8'h08, 64'd0, 8, 0, 0);
    check("t2_lbu", Read_Data, 64'h80);
    run(0, 3'b010, 8'h11, 64'hAABBCCDD11223344, 8, 0, 0);
    check("t3_rd_kept", Read_Data, 64'h80);
    run(1, 3'b001, 8'h20, 64'd0, 1, 3, 0);
    run(1, 3'b010, 8'h30, 64'd0, 8, 0, 1);
    check("t5_rd_zero", Read_Data, 64'd0);
    run(1, 3'b111, 8'h40, 64'd0, 8, 0, 0);
    run(0, 3'b101, 8'h48, 64'h1234, 8, 0, 0);

    for (int n = 0; n < 30; n++)
      run(1'($urandom), 3'($urandom), 8'($urandom_range(0, 240)),
          {$urandom, $urandom}, $urandom_range(0, 8), $urandom_range(0, 3), 0);

    mem[8'h50] = 8'h5A;
    run(1, 3'b000, 8'h50, 64'd0, 8, 0, 0);
    check("pre_rst_rd", Read_Data, 64'h5A);
    @(negedge clk);
    MemRead = 1; MemWrite = 0; funct3 = 3'b011; Mem_Addr = '0; mem_ack = 1;
    @(negedge clk); @(negedge clk);
    #1;
    check("mid_xfer_req", 64'(mem_req), 64'd1);
    reset_n = 0;
    #1;
    check("arst_req", 64'(mem_req), 64'd0);
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_rdata", Read_Data, 64'd0);
    @(negedge clk);
    MemRead = 0; mem_ack = 0; reset_n = 1;
    exp_rd = '0;
    run(1, 3'b011, 8'h00, 64'd0, 8, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
